// File: rtl/mem_access_unit_if.sv
// Core request/response channel plus data-memory strobe bus of the memory access unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface mem_access_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqUnsigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespRData;
  logic        RespErr;
  logic        RespWrite;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic        mRD;
  logic        mWR;
  logic [31:0] DataOut;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, RespReady, DataOut,
    output ReqReady, RespValid, RespRData, RespErr, RespWrite, DAddr, DataIn, Load, Store, mRD, mWR
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, RespReady, DataOut,
    input  ReqReady, RespValid, RespRData, RespErr, RespWrite, DAddr, DataIn, Load, Store, mRD, mWR
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator: validates a core request, issues one
// mRD/mWR strobe cycle, and returns extended load data or a store acknowledgement.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic           CLK,
  input  logic           Reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  span;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        req_err;
  logic        accept;
  logic [31:0] load_ext;

  assign accept = (state == IDLE) && bus.ReqValid;

  // Last byte touched is computed in 33 bits so an access near 2^32 cannot wrap back into range.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    span = 3'd3;
    case (bus.ReqSize)
      2'b00:   span = 3'd0;
      2'b01:   span = 3'd1;
      default: span = 3'd3;
    endcase
  end

  assign last_byte  = {1'b0, bus.ReqAddr} + {30'b0, span};
  assign misaligned = CHECK_ALIGN &&
                      (((bus.ReqSize == 2'b01) && bus.ReqAddr[0]) ||
                       ((bus.ReqSize == 2'b10) && (bus.ReqAddr[1:0] != 2'b00)));
  assign req_err    = (bus.ReqSize == 2'b11) || (last_byte >= 33'(MEM_BYTES)) || misaligned;

  always_comb begin
    load_ext = bus.DataOut;
    case (bus.Load)
      3'b000:  load_ext = {{24{bus.DataOut[7]}}, bus.DataOut[7:0]};
      3'b001:  load_ext = {24'b0, bus.DataOut[7:0]};
      3'b010:  load_ext = {{16{bus.DataOut[15]}}, bus.DataOut[15:0]};
      3'b011:  load_ext = {16'b0, bus.DataOut[15:0]};
      default: load_ext = bus.DataOut;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ReqValid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.RespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from the state register and the latched direction.
  always_comb begin
    bus.ReqReady  = (state == IDLE);
    bus.RespValid = (state == RESP);
    bus.mRD       = (state == ACCESS) && !bus.RespWrite;
    bus.mWR       = (state == ACCESS) &&  bus.RespWrite;
  end

  // NOTE: the datapath registers are reset too, so a reset mid-access discards any pending response.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      bus.DAddr     <= '0;
      bus.DataIn    <= '0;
      bus.Load      <= 3'b100;
      bus.Store     <= 2'b10;
      bus.RespWrite <= 1'b0;
      bus.RespErr   <= 1'b0;
      bus.RespRData <= '0;
    end else if (accept) begin
      bus.DAddr     <= bus.ReqAddr;
      bus.DataIn    <= bus.ReqWData;
      bus.Load      <= {bus.ReqSize == 2'b10, bus.ReqSize == 2'b01,
                        bus.ReqUnsigned && (bus.ReqSize != 2'b10)};
      bus.Store     <= bus.ReqSize;
      bus.RespWrite <= bus.ReqWrite;
      bus.RespErr   <= req_err;
      bus.RespRData <= '0;
    end else if (state == ACCESS) begin
      bus.RespRData <= bus.RespWrite ? 32'h0 : load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random requests checked against
// a byte-array reference memory and an arithmetic model of the access rules.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 1024;
  localparam int AW        = $clog2(MEM_BYTES);

  logic CLK = 1'b0;
  logic Reset;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(1'b1)) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  bit [7:0] mem     [MEM_BYTES];
  bit [7:0] ref_mem [MEM_BYTES];
  int n_checks  = 0;
  int n_fail    = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int exp_rd    = 0;
  int exp_wr    = 0;

  function automatic int store_bytes(input logic [1:0] code);
    return (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
  endfunction

  // Memory the DUT talks to: raw little-endian bytes at DAddr, LSB-aligned.
  always_comb begin
    bus.DataOut = '0;
    for (int i = 0; i < 4; i++)
      if ({32'h0, bus.DAddr} + 64'(i) < 64'(MEM_BYTES))
        bus.DataOut[8*i +: 8] = mem[bus.DAddr[AW-1:0] + AW'(i)];
  end

  always @(posedge CLK) begin
    if (bus.mWR)
      for (int i = 0; i < 4; i++)
        if (i < store_bytes(bus.Store) && ({32'h0, bus.DAddr} + 64'(i) < 64'(MEM_BYTES)))
          mem[bus.DAddr[AW-1:0] + AW'(i)] <= bus.DataIn[8*i +: 8];
  end

  always @(negedge CLK) begin
    if (bus.mRD) rd_cycles <= rd_cycles + 1;
    if (bus.mWR) wr_cycles <= wr_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: error rules and load value computed arithmetically from the byte array.
  function automatic void model(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                                input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int     nb;
    longint last;
    longint val;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'({32'h0, a}) + longint'(nb) - 1;
    err  = (sz == 2'd3) || (last >= longint'(MEM_BYTES)) || ((a % 32'(nb)) != 0);
    rd   = '0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < nb; i++) val += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (!u && val >= (longint'(1) << (8 * nb - 1))) val -= (longint'(1) << (8 * nb));
        rd = val[31:0];
      end
    end
  endfunction

  function automatic logic [2:0] load_code(input bit [1:0] sz, input bit u);
    case (sz)
      2'd0:    return u ? 3'b001 : 3'b000;
      2'd1:    return u ? 3'b011 : 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic do_access(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                           input bit [31:0] wd, input int hold, output logic [31:0] rdata);
    bit        err;
    bit [31:0] exp_rdata;
    model(w, sz, u, a, wd, err, exp_rdata);
    @(negedge CLK);
    check("req_ready_idle", bus.ReqReady, 1);
    bus.ReqWrite    = w;
    bus.ReqSize     = sz;
    bus.ReqUnsigned = u;
    bus.ReqAddr     = a;
    bus.ReqWData    = wd;
    bus.ReqValid    = 1'b1;
    @(posedge CLK);
    #1;
    bus.ReqValid = 1'b0;
    bus.ReqAddr  = $urandom();
    bus.ReqWData = $urandom();
    @(negedge CLK);
    check("req_ready_busy", bus.ReqReady, 0);
    if (err) begin
      check("strobe_on_error", {bus.mRD, bus.mWR}, 0);
      check("resp_valid_error", bus.RespValid, 1);
    end else begin
      check("strobe", {bus.mRD, bus.mWR}, w ? 2'b01 : 2'b10);
      check("resp_valid_early", bus.RespValid, 0);
      check("daddr", bus.DAddr, a);
      if (w) begin
        check("store_code", bus.Store, sz);
        check("data_in", bus.DataIn, wd);
        exp_wr++;
      end else begin
        check("load_code", bus.Load, load_code(sz, u));
        exp_rd++;
      end
      @(negedge CLK);
      check("strobe_off", {bus.mRD, bus.mWR}, 0);
      check("resp_valid", bus.RespValid, 1);
    end
    check("resp_err", bus.RespErr, err);
    check("resp_write", bus.RespWrite, w);
    check("resp_rdata", bus.RespRData, exp_rdata);
    rdata = bus.RespRData;
    repeat (hold) begin
      @(negedge CLK);
      check("hold_valid", bus.RespValid, 1);
      check("hold_rdata", bus.RespRData, exp_rdata);
      check("hold_ready", bus.ReqReady, 0);
      check("hold_strobe", {bus.mRD, bus.mWR}, 0);
    end
    bus.RespReady = 1'b1;
    @(posedge CLK);
    #1;
    bus.RespReady = 1'b0;
    check("resp_valid_drop", bus.RespValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    bit          w;
    bit          u;
    bit [1:0]    sz;
    bit [31:0]   a;
    bit          e;
    bit [31:0]   r_exp;
    logic [9:0]  strobe_log;
    int          mism;

    Reset           = 1'b0;
    bus.ReqValid    = 1'b0;
    bus.ReqWrite    = 1'b0;
    bus.ReqSize     = 2'b00;
    bus.ReqUnsigned = 1'b0;
    bus.ReqAddr     = '0;
    bus.ReqWData    = '0;
    bus.RespReady   = 1'b0;
    #12;
    check("rst_req_ready", bus.ReqReady, 1);
    check("rst_resp_valid", bus.RespValid, 0);
    check("rst_strobes", {bus.mRD, bus.mWR}, 0);
    check("rst_resp_flags", {bus.RespErr, bus.RespWrite}, 0);
    check("rst_daddr", bus.DAddr, 0);
    check("rst_data_in", bus.DataIn, 0);
    check("rst_rdata", bus.RespRData, 0);
    check("rst_load", bus.Load, 3'b100);
    check("rst_store", bus.Store, 2'b10);
    @(negedge CLK);
    Reset = 1'b1;

    // Directed: word store then every load flavour from the same address.
    do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7F80, 0, r);
    check("sw_ack_rdata", r, 32'h0);
    do_access(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, r);
    check("lb_value", r, 32'hFFFF_FF80);
    do_access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, r);
    check("lbu_value", r, 32'h0000_0080);
    do_access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, r);
    check("lh_value", r, 32'h0000_7F80);
    do_access(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0, r);
    check("lhu_value", r, 32'h0000_7F80);
    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r);
    check("lw_value", r, 32'h8001_7F80);

    // Directed error cases.
    do_access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, r);
    do_access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, r);
    do_access(1'b1, 2'd2, 1'b0, 32'h3FE, 32'hDEAD_BEEF, 0, r);
    do_access(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234_5678, 2, r);
    do_access(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, r);

    // Random requests, biased towards aligned and boundary addresses.
    for (int k = 0; k < 160; k++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, MEM_BYTES - 1)) & 32'hFFFF_FFFC;
        1:       a = 32'($urandom_range(0, MEM_BYTES - 1));
        2:       a = 32'(MEM_BYTES - 6 + int'($urandom_range(0, 8)));
        default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      do_access(w, sz, u, a, $urandom(), int'($urandom_range(0, 2)), r);
    end

    // Back-to-back sb then lbu with RespReady held high.
    model(1'b1, 2'd0, 1'b0, 32'h20, 32'h0000_00AB, e, r_exp);
    model(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, e, r_exp);
    exp_wr++;
    exp_rd++;
    @(negedge CLK);
    bus.RespReady   = 1'b1;
    bus.ReqWrite    = 1'b1;
    bus.ReqSize     = 2'd0;
    bus.ReqUnsigned = 1'b0;
    bus.ReqAddr     = 32'h20;
    bus.ReqWData    = 32'h0000_00AB;
    bus.ReqValid    = 1'b1;
    @(posedge CLK);
    #1;
    bus.ReqWrite    = 1'b0;
    bus.ReqUnsigned = 1'b1;
    bus.ReqWData    = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      strobe_log[2*i +: 2] = {bus.mRD, bus.mWR};
      if (i == 3) bus.ReqValid = 1'b0;
      if (i == 4) begin
        check("b2b_resp_valid", bus.RespValid, 1);
        check("b2b_lbu_model", bus.RespRData, r_exp);
        check("b2b_lbu_value", bus.RespRData, 32'h0000_00AB);
      end
    end
    check("b2b_strobe_pattern", strobe_log, 10'b00_10_00_00_01);
    @(posedge CLK);
    #1;
    bus.RespReady = 1'b0;

    // Reset asserted while the read strobe is high.
    @(negedge CLK);
    bus.ReqWrite = 1'b0;
    bus.ReqSize  = 2'd2;
    bus.ReqAddr  = 32'h10;
    bus.ReqValid = 1'b1;
    @(posedge CLK);
    #1;
    bus.ReqValid = 1'b0;
    #1;
    check("rst_mid_strobe_before", bus.mRD, 1);
    Reset = 1'b0;
    #1;
    check("rst_mid_strobes_drop", {bus.mRD, bus.mWR}, 0);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    check("rst_mid_req_ready", bus.ReqReady, 1);
    check("rst_mid_resp_valid", bus.RespValid, 0);
    check("rst_mid_rdata", bus.RespRData, 0);

    // Final memory image and strobe accounting.
    repeat (2) @(negedge CLK);
    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] != ref_mem[i]) mism++;
    check("mem_image_mismatches", mism, 0);
    check("rd_strobe_cycles", rd_cycles, exp_rd);
    check("wr_strobe_cycles", wr_cycles, exp_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
